svcs_trnx_framer: RTL and testbench

Synthesizable multi-channel transaction framer for the SVCS link. It accepts per-channel transaction headers (type, id, data type, payload length) followed by payload words. A round-robin arbiter picks one channel, and the block serialises the header and payload into a single registered word stream, optionally closed by an XOR checksum word. It sits between the RTL transaction sources and the socket-side bridge, and produces the same header/payload ordering that the SVCS software domain expects.

---
 rtl/svcs_rtl_pkg.sv | 18 +
 rtl/svcs_rr_arbiter.sv | 39 +++
 rtl/svcs_trnx_framer.sv | 242 ++++++++++++++++++++++++
 tb/tb_svcs_trnx_framer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/svcs_rtl_pkg.sv
// Shared definitions for the SVCS transaction framer: FSM encoding and header word layout.
package svcs_rtl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } framer_state_t;

  localparam logic [1:0] HDR_TYPE  = 2'd0;
  localparam logic [1:0] HDR_ID    = 2'd1;
  localparam logic [1:0] HDR_DTYPE = 2'd2;
  localparam logic [1:0] HDR_LEN   = 2'd3;

  localparam int HDR_FIELD_W = 32;

endpackage

// File: rtl/svcs_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_rr_ptr, with wrap.
module svcs_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_rr_ptr,
  output logic [N_CH-1:0] o_gnt,
  output logic [CH_W-1:0] o_gnt_idx,
  output logic            o_gnt_any
);

  localparam int SUM_W = CH_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [CH_W-1:0]  w_c;

  // Scan channels starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_any = 1'b0;
    w_sum     = '0;
    w_c       = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = {1'b0, i_rr_ptr} + SUM_W'(i);
      w_sum = (w_sum >= SUM_W'(N_CH)) ? (w_sum - SUM_W'(N_CH)) : w_sum;
      w_c   = w_sum[CH_W-1:0];
      if (!o_gnt_any && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_gnt_idx  = w_c;
        o_gnt_any  = 1'b1;
      end else begin
        o_gnt_any = o_gnt_any;
      end
    end
  end

endmodule

// File: rtl/svcs_trnx_framer.sv
// Multi-channel transaction framer: arbitrates headers, serialises header + payload words.
// Optional XOR checksum trailer word is built when SVCS_FRAMER_CHKSUM_EN is defined.
module svcs_trnx_framer
  import svcs_rtl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int LEN_W  = 12,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             hdr_valid,
  output logic [N_CH-1:0]             hdr_ready,
  input  logic [N_CH*HDR_FIELD_W-1:0] hdr_trnx_type,
  input  logic [N_CH*HDR_FIELD_W-1:0] hdr_trnx_id,
  input  logic [N_CH*HDR_FIELD_W-1:0] hdr_data_type,
  input  logic [N_CH*LEN_W-1:0]       hdr_n_words,
  input  logic [N_CH-1:0]             pl_valid,
  output logic [N_CH-1:0]             pl_ready,
  input  logic [N_CH*DATA_W-1:0]      pl_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_sof,
  output logic                        out_last,
  output logic [CH_W-1:0]             out_ch
);

  framer_state_t r_state, w_state_nxt;
  logic [1:0]             r_idx, w_idx_nxt;
  logic [CH_W-1:0]        r_ch, r_rr_ptr, w_ptr_nxt;
  logic [HDR_FIELD_W-1:0] r_type, r_id, r_dtype;
  logic [LEN_W-1:0]       r_cnt;
  logic                   r_out_valid, r_out_sof, r_out_last;
  logic [DATA_W-1:0]      r_out_data;
  logic [CH_W-1:0]        r_out_ch;
`ifdef SVCS_FRAMER_CHKSUM_EN
  logic [DATA_W-1:0]      r_chk;
`endif

  logic [N_CH-1:0]        w_gnt;
  logic [CH_W-1:0]        w_gnt_idx;
  logic                   w_gnt_any;
  logic [HDR_FIELD_W-1:0] w_sel_type, w_sel_id, w_sel_dtype;
  logic [LEN_W-1:0]       w_sel_len;
  logic                   w_pl_valid_g;
  logic [DATA_W-1:0]      w_pl_data_g;
  logic                   w_load_ok, w_ld, w_accept, w_take, w_sof, w_last;
  logic [DATA_W-1:0]      w_word;
  logic [CH_W-1:0]        w_word_ch;

  svcs_rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .i_req     (hdr_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign w_sel_type   = hdr_trnx_type[w_gnt_idx*HDR_FIELD_W +: HDR_FIELD_W];
  assign w_sel_id     = hdr_trnx_id[w_gnt_idx*HDR_FIELD_W +: HDR_FIELD_W];
  assign w_sel_dtype  = hdr_data_type[w_gnt_idx*HDR_FIELD_W +: HDR_FIELD_W];
  assign w_sel_len    = hdr_n_words[w_gnt_idx*LEN_W +: LEN_W];
  assign w_pl_valid_g = pl_valid[r_ch];
  assign w_pl_data_g  = pl_data[r_ch*DATA_W +: DATA_W];
  assign w_load_ok    = !r_out_valid || out_ready;
  assign w_ptr_nxt    = (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : (w_gnt_idx + CH_W'(1));

  assign hdr_ready = (r_state == ST_IDLE && w_load_ok) ? w_gnt : '0;

  // Payload handshake is offered only to the granted channel.
  always_comb begin
    pl_ready = '0;
    if (r_state == ST_PAY && w_load_ok) begin
      pl_ready[r_ch] = 1'b1;
    end else begin
      pl_ready = '0;
    end
  end

  // Header word 0 is loaded in the acceptance cycle so it is visible one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ld        = 1'b0;
    w_accept    = 1'b0;
    w_take      = 1'b0;
    w_word      = '0;
    w_sof       = 1'b0;
    w_last      = 1'b0;
    w_word_ch   = r_ch;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any && w_load_ok) begin
          w_accept    = 1'b1;
          w_ld        = 1'b1;
          w_word      = DATA_W'(w_sel_type);
          w_sof       = 1'b1;
          w_word_ch   = w_gnt_idx;
          w_state_nxt = ST_HDR;
          w_idx_nxt   = HDR_ID;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (w_load_ok) begin
          w_ld = 1'b1;
          case (r_idx)
            HDR_TYPE:  w_word = DATA_W'(r_type);
            HDR_ID:    w_word = DATA_W'(r_id);
            HDR_DTYPE: w_word = DATA_W'(r_dtype);
            default:   w_word = DATA_W'(r_cnt);
          endcase
          if (r_idx == HDR_LEN) begin
            w_idx_nxt = HDR_TYPE;
            if (r_cnt != '0) begin
              w_state_nxt = ST_PAY;
            end else begin
`ifdef SVCS_FRAMER_CHKSUM_EN
              w_state_nxt = ST_CHK;
`else
              w_state_nxt = ST_IDLE;
              w_last      = 1'b1;
`endif
            end
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_PAY: begin
        if (w_load_ok && w_pl_valid_g) begin
          w_ld   = 1'b1;
          w_take = 1'b1;
          w_word = w_pl_data_g;
          // Leave at a count of one so a full-scale length never wraps.
          if (r_cnt == LEN_W'(1)) begin
`ifdef SVCS_FRAMER_CHKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_state_nxt = ST_IDLE;
            w_last      = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_PAY;
          end
        end else begin
          w_state_nxt = ST_PAY;
        end
      end
`ifdef SVCS_FRAMER_CHKSUM_EN
      ST_CHK: begin
        if (w_load_ok) begin
          w_ld        = 1'b1;
          w_word      = r_chk;
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CHK;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, captured header fields, payload counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= HDR_TYPE;
      r_ch     <= '0;
      r_rr_ptr <= '0;
      r_type   <= '0;
      r_id     <= '0;
      r_dtype  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_ch     <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
        r_type   <= w_sel_type;
        r_id     <= w_sel_id;
        r_dtype  <= w_sel_dtype;
        r_cnt    <= w_sel_len;
      end else if (w_take) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Output register; holds its contents while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_ld) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_sof   <= w_sof;
      r_out_last  <= w_last;
      r_out_ch    <= w_word_ch;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

`ifdef SVCS_FRAMER_CHKSUM_EN
  // Running XOR of every header and payload word of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (w_accept) begin
      r_chk <= w_word;
    end else if (w_ld && r_state != ST_CHK) begin
      r_chk <= r_chk ^ w_word;
    end else begin
      r_chk <= r_chk;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_svcs_trnx_framer.sv
// Scoreboard bench for svcs_trnx_framer: expected words are queued at header acceptance
// and a separate monitor compares them against every accepted output word.
module tb_svcs_trnx_framer;

  localparam int DATA_W = 32;
  localparam int N_CH   = 4;
  localparam int LEN_W  = 12;
  localparam int CH_W   = 2;
`ifdef SVCS_FRAMER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      ty;
    logic [31:0]      id;
    logic [31:0]      dt;
    logic [LEN_W-1:0] n;
    logic [31:0]      base;
  } frame_t;
  typedef logic [DATA_W+2+CH_W-1:0] word_t;

  logic                  clk, rst_n;
  logic [N_CH-1:0]       hdr_valid, hdr_ready, pl_valid, pl_ready;
  logic [N_CH*32-1:0]    hdr_trnx_type, hdr_trnx_id, hdr_data_type;
  logic [N_CH*LEN_W-1:0] hdr_n_words;
  logic [N_CH*DATA_W-1:0] pl_data;
  logic                  out_valid, out_ready, out_sof, out_last;
  logic [DATA_W-1:0]     out_data;
  logic [CH_W-1:0]       out_ch;

  svcs_trnx_framer #(.DATA_W(DATA_W), .N_CH(N_CH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_trnx_type(hdr_trnx_type), .hdr_trnx_id(hdr_trnx_id),
    .hdr_data_type(hdr_data_type), .hdr_n_words(hdr_n_words),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_last(out_last), .out_ch(out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  word_t  sb[$];
  frame_t fq[N_CH][$];
  frame_t cur[N_CH];
  int     ph[N_CH];
  int     kk[N_CH];
  int     mp;
  int     hold_ch, hold_at, hold_left;
  bit     hold_now, rdy_toggle;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [31:0] ty, id, dt, input int n, input logic [31:0] base);
    frame_t f;
    f.ty = ty; f.id = id; f.dt = dt; f.n = LEN_W'(n); f.base = base;
    return f;
  endfunction

  function automatic int model_grant();
    int c;
    for (int i = 0; i < N_CH; i++) begin
      c = (mp + i) % N_CH;
      if (hdr_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_frame(input int g, input frame_t f);
    logic [31:0]     x, w;
    logic [CH_W-1:0] ch;
    ch = CH_W'(g);
    x  = f.ty ^ f.id ^ f.dt ^ 32'(f.n);
    sb.push_back({f.ty, 1'b1, 1'b0, ch});
    sb.push_back({f.id, 1'b0, 1'b0, ch});
    sb.push_back({f.dt, 1'b0, 1'b0, ch});
    sb.push_back({32'(f.n), 1'b0, (f.n == '0) && !CHK, ch});
    for (int i = 0; i < int'(f.n); i++) begin
      w = f.base + 32'(i);
      x = x ^ w;
      sb.push_back({w, 1'b0, (i == int'(f.n) - 1) && !CHK, ch});
    end
    if (CHK) sb.push_back({x, 1'b0, 1'b1, ch});
  endtask

  task automatic step();
    logic [N_CH-1:0] hacc, pacc, expp, one;
    int g;
    frame_t f;
    one = 1;
    @(negedge clk);
    hacc = hdr_valid & hdr_ready;
    pacc = pl_valid & pl_ready;
    if (hdr_ready != '0) begin
      g = model_grant();
      if (g < 0) begin
        chk("hdr_ready_unrequested", 64'(hdr_ready), 64'(0));
      end else begin
        chk("hdr_grant", 64'(hdr_ready), 64'(one << g));
        push_frame(g, fq[g][0]);
        mp = (g + 1) % N_CH;
      end
    end
    if (pl_ready != '0) begin
      expp = '0;
      for (int c = 0; c < N_CH; c++) expp[c] = (ph[c] == 1);
      chk("pl_ready_owner", 64'(pl_ready), 64'(expp));
    end
    if (hold_now && hold_left == 2) chk("valid_drop_on_pl_stall", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) begin
      if (hacc[c]) begin
        cur[c] = fq[c].pop_front();
        if (cur[c].n != '0) begin ph[c] = 1; kk[c] = 0; end
      end else if (pacc[c]) begin
        kk[c]++;
        if (kk[c] == int'(cur[c].n)) ph[c] = 0;
      end
    end
    hdr_valid = '0;
    pl_valid  = '0;
    hold_now  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ph[c] == 0 && fq[c].size() > 0) begin
        f = fq[c][0];
        hdr_valid[c] = 1'b1;
        hdr_trnx_type[c*32 +: 32]   = f.ty;
        hdr_trnx_id[c*32 +: 32]     = f.id;
        hdr_data_type[c*32 +: 32]   = f.dt;
        hdr_n_words[c*LEN_W +: LEN_W] = f.n;
      end
      if (ph[c] == 1) begin
        pl_data[c*DATA_W +: DATA_W] = cur[c].base + 32'(kk[c]);
        if (c == hold_ch && kk[c] == hold_at && hold_left > 0) begin
          hold_left--;
          hold_now = 1'b1;
        end else begin
          pl_valid[c] = 1'b1;
        end
      end
    end
    out_ready = rdy_toggle ? !out_ready : 1'b1;
  endtask

  function automatic bit all_done();
    bit d;
    d = (sb.size() == 0) && !out_valid;
    for (int c = 0; c < N_CH; c++) d = d && (fq[c].size() == 0) && (ph[c] == 0);
    return d;
  endfunction

  task automatic run(input string nm, input int budget);
    for (int i = 0; i < budget && !all_done(); i++) step();
    chk(nm, 64'(all_done()), 64'(1));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_out_data"},  64'(out_data),  64'(0));
    chk({nm, "_out_sof"},   64'(out_sof),   64'(0));
    chk({nm, "_out_last"},  64'(out_last),  64'(0));
    chk({nm, "_out_ch"},    64'(out_ch),    64'(0));
    chk({nm, "_hdr_ready"}, 64'(hdr_ready), 64'(0));
    chk({nm, "_pl_ready"},  64'(pl_ready),  64'(0));
  endtask

  // Monitor: pops one expected word per accepted output word, checks hold-while-stalled.
  initial begin : monitor
    word_t got, exp, held;
    bit stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      got = {out_data, out_sof, out_last, out_ch};
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stall_hold", {63'(got), out_valid}, {63'(held), 1'b1});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", 64'(got), 64'(0));
            if (got == '0) begin n_err++; $display("FAIL unexpected_word: zero word with empty scoreboard"); end
          end else begin
            exp = sb.pop_front();
            chk("out_word", 64'(got), 64'(exp));
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held    = got;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    rst_n = 1'b0;
    hdr_valid = '0; pl_valid = '0; out_ready = 1'b1;
    hdr_trnx_type = '0; hdr_trnx_id = '0; hdr_data_type = '0; hdr_n_words = '0; pl_data = '0;
    mp = 0; hold_ch = -1; hold_at = 0; hold_left = 0; hold_now = 1'b0; rdy_toggle = 1'b0;
    for (int c = 0; c < N_CH; c++) begin ph[c] = 0; kk[c] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_init");
    rst_n = 1'b1;

    fq[0].push_back(mk(32'h11, 32'h22, 32'h33, 2, 32'hA));
    run("basic_2word", 100);

    fq[3].push_back(mk(32'h44, 32'h55, 32'h66, 0, 32'h0));
    run("zero_payload", 100);

    for (int c = 0; c < N_CH; c++) fq[c].push_back(mk(32'h70 + 32'(c), 32'h80 + 32'(c), 32'h90, 1, 32'h100 + 32'(c)));
    run("all_channels", 200);

    rdy_toggle = 1'b1;
    fq[2].push_back(mk(32'hA1, 32'hA2, 32'hA3, 4, 32'h200));
    run("ready_toggle", 200);
    rdy_toggle = 1'b0;

    hold_ch = 3; hold_at = 2; hold_left = 5;
    fq[3].push_back(mk(32'hB1, 32'hB2, 32'hB3, 4, 32'h300));
    run("pl_valid_stall", 200);
    hold_ch = -1;

    fq[0].push_back(mk(32'hC1, 32'hC2, 32'hC3, 4095, 32'h1000));
    run("max_len", 5000);

    fq[1].push_back(mk(32'hD1, 32'hD2, 32'hD3, 3, 32'h500));
    for (int i = 0; i < 50 && !(ph[1] == 1 && kk[1] == 1); i++) step();
    reached = (ph[1] == 1 && kk[1] == 1);
    chk("reach_payload_word1", 64'(reached), 64'(1));
    rst_n = 1'b0;
    #2;
    check_reset("rst_mid");
    sb.delete();
    for (int c = 0; c < N_CH; c++) begin fq[c].delete(); ph[c] = 0; kk[c] = 0; end
    hdr_valid = '0; pl_valid = '0; out_ready = 1'b1; mp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fq[1].push_back(mk(32'hE1, 32'hE2, 32'hE3, 2, 32'h600));
    fq[3].push_back(mk(32'hF1, 32'hF2, 32'hF3, 1, 32'h700));
    run("post_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
